// File: rtl/t_table_reader.sv
// Streams rows 0..I-1 of the T-table BRAM to a valid/ready consumer,
// hiding the fixed BRAM read latency behind a credit-limited output FIFO.
module t_table_reader #(
    parameter int BIT_WIDTH    = 32,
    parameter int I            = 160,
    parameter int NU_VALUES    = 3,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           start,
    output logic                           bram_rd_en,
    output logic [$clog2(I)-1:0]           bram_addr,
    input  logic [NU_VALUES*BIT_WIDTH-1:0] bram_data,
    output logic [NU_VALUES*BIT_WIDTH-1:0] out_data,
    output logic [$clog2(I)-1:0]           out_index,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done
);

    localparam int DW = NU_VALUES * BIT_WIDTH;
    localparam int AW = $clog2(I);
    localparam int PW = $clog2(I + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int L  = READ_LATENCY;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } entry_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [L-1:0]  pipe_vld_q, pipe_vld_d;
    logic [AW-1:0] pipe_addr_q [L];
    logic [AW-1:0] pipe_addr_d [L];

    entry_t        mem_q [FIFO_DEPTH];
    logic [FW-1:0] head_q, head_d;
    logic [FW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [SW-1:0] inflight;
    logic [SW-1:0] credit;
    logic          rd_en;
    logic          push;
    logic          pop;
    entry_t        head_entry;

    function automatic logic [FW-1:0] wrap_inc(input logic [FW-1:0] p);
        return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + FW'(1);
    endfunction

    // Credit: a read may only be issued if its row is guaranteed a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < L; k++) begin
            inflight = inflight + SW'(pipe_vld_q[k]);
        end
        credit = SW'(count_q) + inflight;
        rd_en  = (state_q == ISSUE)
              && (rd_ptr_q != PW'(I))
              && (credit < SW'(FIFO_DEPTH));
    end

    always_comb begin
        pipe_vld_d     = '0;
        pipe_vld_d[0]  = rd_en;
        pipe_addr_d[0] = AW'(rd_ptr_q);
        for (int k = 1; k < L; k++) begin
            pipe_vld_d[k]  = pipe_vld_q[k-1];
            pipe_addr_d[k] = pipe_addr_q[k-1];
        end
    end

    assign push       = pipe_vld_q[L-1];
    assign head_entry = mem_q[head_q];
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid & out_ready;

    always_comb begin
        head_d  = pop  ? wrap_inc(head_q) : head_q;
        tail_d  = push ? wrap_inc(tail_q) : tail_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ISSUE;
                    rd_ptr_d = '0;
                    busy_d   = 1'b1;
                end
            end
            ISSUE: begin
                if (rd_en) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    if (rd_ptr_q == PW'(I - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((count_d == '0) && (pipe_vld_d == '0)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pipe_vld_q <= '0;
            for (int k = 0; k < L; k++) begin
                pipe_addr_q[k] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pipe_vld_q <= pipe_vld_d;
            for (int k = 0; k < L; k++) begin
                pipe_addr_q[k] <= pipe_addr_d[k];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[tail_q] <= {pipe_addr_q[L-1], bram_data};
        end
    end

    // Storage is not cleared, so the head is masked until it holds a real row.
    assign out_data   = out_valid ? head_entry.data : '0;
    assign out_index  = out_valid ? head_entry.idx : '0;
    assign out_last   = out_valid && (head_entry.idx == AW'(I - 1));
    assign bram_rd_en = rd_en;
    assign bram_addr  = AW'(rd_ptr_q);
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_t_table_reader.sv
// Scoreboard bench for t_table_reader: BRAM model with fixed latency,
// expected rows queued at start and compared on every handshake.
module tb_t_table_reader;

    localparam int BW = 32;
    localparam int NI = 160;
    localparam int NV = 3;
    localparam int DW = NV * BW;
    localparam int AW = 8;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start;
    logic          bram_rd_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    int rdy_mode = 0;
    bit lat_chk  = 0;
    int ph;

    int            exp_q[$];
    bit            m_busy, exp_done, nxt_done, first_pending, stall_prev;
    int            exp_addr, outstanding, n_beats, start_cyc, last_hs;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;

    t_table_reader #(
        .BIT_WIDTH   (BW),
        .I           (NI),
        .NU_VALUES   (NV),
        .READ_LATENCY(2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start     (start),
        .bram_rd_en(bram_rd_en),
        .bram_addr (bram_addr),
        .bram_data (bram_data),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [DW-1:0] row(input int r);
        return {BW'(r + 2), BW'(r + 1), BW'(r)};
    endfunction

    // Two-stage BRAM read model
    logic [DW-1:0] rd_d1;
    always @(posedge clk_in) begin
        if (bram_rd_en) rd_d1 <= row(int'(bram_addr));
        bram_data <= rd_d1;
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        ph = 0;
        forever begin
            @(posedge clk_in);
            #1;
            case (rdy_mode)
                1: begin
                    out_ready = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                exp_q.delete();
                m_busy = 0; exp_done = 0; nxt_done = 0;
                exp_addr = 0; outstanding = 0; n_beats = 0;
                stall_prev = 0; first_pending = 0;
            end else begin
                chk("busy", busy, m_busy);
                chk("rd_en", bram_rd_en,
                    m_busy && (exp_addr < NI) && (outstanding < 4));
                if (bram_rd_en) begin
                    chk("rd_addr", bram_addr, exp_addr);
                    exp_addr++;
                    outstanding++;
                end
                if (out_valid) begin
                    if (stall_prev) begin
                        chk("stable_data", out_data, prev_data);
                        chk("stable_idx", out_index, prev_idx);
                    end
                    if (out_ready) begin
                        chk("beat_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            int e;
                            e = exp_q.pop_front();
                            chk("index", out_index, e);
                            chk("data", out_data, row(e));
                            chk("last", out_last, e == NI - 1);
                            if (lat_chk && first_pending)
                                chk("latency", cyc - start_cyc, 3);
                            else if (lat_chk)
                                chk("gap", cyc - last_hs, 1);
                            last_hs = cyc;
                            first_pending = 0;
                            n_beats++;
                            outstanding--;
                            if (e == NI - 1) nxt_done = 1;
                        end
                    end
                end
                stall_prev = out_valid && !out_ready;
                prev_data  = out_data;
                prev_idx   = out_index;
                if (done || exp_done) chk("done", done, exp_done);
                exp_done = nxt_done;
                nxt_done = 0;
                if (start && !m_busy) begin
                    exp_q.delete();
                    for (int r = 0; r < NI; r++) exp_q.push_back(r);
                    m_busy = 1;
                    first_pending = 1;
                    start_cyc = cyc + 1;
                    exp_addr = 0;
                    outstanding = 0;
                    n_beats = 0;
                end
                if (exp_done) m_busy = 0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk_in); #1 start = 1'b1;
        @(posedge clk_in); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk_in);
            if (done) seen = 1;
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic wait_beats(input int n, input int bound);
        bit ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk_in);
            if (n_beats >= n) ok = 1;
        end
        chk("beats_reached", ok, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rd_en"}, bram_rd_en, 0);
        chk({tag, "_addr"}, bram_addr, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_index"}, out_index, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        rst_in = 1'b1;
        start  = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        check_idle_outputs("reset");

        lat_chk = 1;
        pulse_start();
        wait_done(400);
        chk("beats_full", n_beats, NI);

        pulse_start();
        wait_done(400);
        chk("beats_b2b", n_beats, NI);
        lat_chk = 0;

        rdy_mode = 1;
        pulse_start();
        wait_done(1200);
        chk("beats_bp", n_beats, NI);

        rdy_mode = 2;
        pulse_start();
        repeat (20) @(posedge clk_in);
        chk("stall_reads", exp_addr, 4);
        chk("stall_rd_en", bram_rd_en, 0);
        rdy_mode = 0;
        wait_done(400);
        chk("beats_stall", n_beats, NI);

        pulse_start();
        wait_beats(50, 400);
        pulse_start();
        wait_done(400);
        chk("beats_dbl", n_beats, NI);
        repeat (5) @(negedge clk_in);

        pulse_start();
        wait_beats(80, 400);
        @(posedge clk_in); #1 rst_in = 1'b1;
        @(posedge clk_in); #1 rst_in = 1'b0;
        @(negedge clk_in);
        check_idle_outputs("midrst");
        repeat (6) begin
            @(negedge clk_in);
            chk("no_stale", out_valid, 0);
        end
        pulse_start();
        wait_done(400);
        chk("beats_after_rst", n_beats, NI);
        repeat (3) @(negedge clk_in);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
